// File: rtl/conv_weight_loader.sv
// conv_weight_loader: streams a conv layer's kernel, bias, MACC coeff and
// layer scale words from a valid/ready word source into the conv weight port.
// Ports: clk; rst_n (synchronous, active low); start/abort load control;
// s_data/s_valid/s_ready parameter word stream; weight_wr_addr/data/en
// conv write port (registered, one cycle after each accepted word);
// busy (load in progress); done (one-cycle pulse with the final write).
module conv_weight_loader #(
  parameter int KERNEL_0              = 3,
  parameter int KERNEL_1              = 3,
  parameter int IN_CHANNEL            = 2,
  parameter int OUT_CHANNEL           = 2,
  parameter int KERNEL_BASE_ADDR      = 0,
  parameter int BIAS_BASE_ADDR        =
    KERNEL_BASE_ADDR + KERNEL_0*KERNEL_1*IN_CHANNEL*OUT_CHANNEL,
  parameter int MACC_COEFF_BASE_ADDR  = BIAS_BASE_ADDR + OUT_CHANNEL,
  parameter int LAYER_SCALE_BASE_ADDR = MACC_COEFF_BASE_ADDR + 1,
  parameter int COEFF_W               = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] weight_wr_data,
  output logic [31:0] weight_wr_addr,
  output logic        weight_wr_en,
  output logic        busy,
  output logic        done
);

  localparam int KERNEL_WORDS =
    KERNEL_0 * KERNEL_1 * IN_CHANNEL * OUT_CHANNEL;
  localparam int TOTAL_WORDS = KERNEL_WORDS + OUT_CHANNEL + 2;
  localparam int IDX_W = $clog2(TOTAL_WORDS) + 1;

  localparam logic [IDX_W-1:0] KERNEL_LAST =
    IDX_W'(KERNEL_WORDS - 1);
  localparam logic [IDX_W-1:0] BIAS_LAST =
    IDX_W'(OUT_CHANNEL - 1);

  // Coeff and scale words only carry COEFF_W significant bits.
  localparam logic [31:0] COEFF_MASK =
    (COEFF_W >= 32) ? 32'hFFFF_FFFF :
    32'((64'd1 << COEFF_W) - 64'd1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KERNEL,
    S_BIAS,
    S_COEFF,
    S_SCALE,
    S_DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic             wr_en_q;
  logic             wr_en_d;
  logic [31:0]      wr_addr_q;
  logic [31:0]      wr_addr_d;
  logic [31:0]      wr_data_q;
  logic [31:0]      wr_data_d;
  logic             done_q;
  logic             done_d;
  logic             beat;
  logic             in_load;

  assign in_load = (state_q == S_KERNEL) ||
                   (state_q == S_BIAS)   ||
                   (state_q == S_COEFF)  ||
                   (state_q == S_SCALE);

  assign s_ready        = in_load;
  assign beat           = s_valid & in_load;
  assign busy           = (state_q != S_IDLE);
  assign weight_wr_en   = wr_en_q;
  assign weight_wr_addr = wr_addr_q;
  assign weight_wr_data = wr_data_q;
  assign done           = done_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_KERNEL;
          idx_d   = '0;
        end
      end
      S_KERNEL: begin
        if (beat) begin
          wr_en_d   = 1'b1;
          wr_addr_d = 32'(KERNEL_BASE_ADDR) + 32'(idx_q);
          wr_data_d = s_data;
          if (idx_q == KERNEL_LAST) begin
            state_d = S_BIAS;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_BIAS: begin
        if (beat) begin
          wr_en_d   = 1'b1;
          wr_addr_d = 32'(BIAS_BASE_ADDR) + 32'(idx_q);
          wr_data_d = s_data;
          if (idx_q == BIAS_LAST) begin
            state_d = S_COEFF;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_COEFF: begin
        if (beat) begin
          wr_en_d   = 1'b1;
          wr_addr_d = 32'(MACC_COEFF_BASE_ADDR);
          wr_data_d = s_data & COEFF_MASK;
          state_d   = S_SCALE;
        end
      end
      S_SCALE: begin
        if (beat) begin
          wr_en_d   = 1'b1;
          wr_addr_d = 32'(LAYER_SCALE_BASE_ADDR);
          wr_data_d = s_data & COEFF_MASK;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides any beat taken on the same edge: nothing is written
    // and the port keeps its previous address/data.
    if (abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      idx_d     = '0;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_conv_weight_loader.sv
// tb_conv_weight_loader: scoreboard bench for conv_weight_loader.
// Default instance (40 words) plus a 1x1, IC=4, OC=8 instance (42 words).
module tb_conv_weight_loader;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] weight_wr_data;
  logic [31:0] weight_wr_addr;
  logic        weight_wr_en;
  logic        busy;
  logic        done;

  logic        start_b;
  logic        abort_b;
  logic [31:0] s_data_b;
  logic        s_valid_b;
  logic        s_ready_b;
  logic [31:0] wr_data_b;
  logic [31:0] wr_addr_b;
  logic        wr_en_b;
  logic        busy_b;
  logic        done_b;

  int  n_cmp;
  int  n_err;
  wr_t q[$];
  wr_t e;

  conv_weight_loader u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .weight_wr_data (weight_wr_data),
    .weight_wr_addr (weight_wr_addr),
    .weight_wr_en   (weight_wr_en),
    .busy           (busy),
    .done           (done)
  );

  conv_weight_loader #(
    .KERNEL_0    (1),
    .KERNEL_1    (1),
    .IN_CHANNEL  (4),
    .OUT_CHANNEL (8)
  ) u_dut_b (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start_b),
    .abort          (abort_b),
    .s_data         (s_data_b),
    .s_valid        (s_valid_b),
    .s_ready        (s_ready_b),
    .weight_wr_data (wr_data_b),
    .weight_wr_addr (wr_addr_b),
    .weight_wr_en   (wr_en_b),
    .busy           (busy_b),
    .done           (done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    s_valid = 1'b1;
    s_data = 32'hFFFF_FFFF;
    tick();
    tick();
    n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready got=%b exp=0", s_ready); end
    n_cmp++; if (weight_wr_en !== 1'b0) begin n_err++; $display("FAIL rst_en got=%b exp=0", weight_wr_en); end
    n_cmp++; if (weight_wr_addr !== 32'd0) begin n_err++; $display("FAIL rst_addr got=%h exp=0", weight_wr_addr); end
    n_cmp++; if (weight_wr_data !== 32'd0) begin n_err++; $display("FAIL rst_data got=%h exp=0", weight_wr_data); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done got=%b exp=0", done); end
    n_cmp++; if (busy_b !== 1'b0) begin n_err++; $display("FAIL rst_busy_b got=%b exp=0", busy_b); end
    start = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    rst_n = 1'b1;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_full_load();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL full_ready got=%b exp=1", s_ready); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL full_busy got=%b exp=1", busy); end
    for (int n = 0; n < 40; n++) begin
      s_valid = 1'b1;
      s_data = 32'(n);
      q.push_back('{addr: 32'(n), data: 32'(n)});
      tick();
      n_cmp++; if (weight_wr_en !== 1'b1) begin n_err++; $display("FAIL full_en n=%0d got=%b exp=1", n, weight_wr_en); end
      if (weight_wr_en === 1'b1 && q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (weight_wr_addr !== e.addr || weight_wr_data !== e.data) begin
          n_err++;
          $display("FAIL full_wr n=%0d got=%h/%h exp=%h/%h", n, weight_wr_addr, weight_wr_data, e.addr, e.data);
        end
      end
      n_cmp++; if (done !== (n == 39)) begin n_err++; $display("FAIL full_done n=%0d got=%b exp=%b", n, done, n == 39); end
      if (n == 39) s_valid = 1'b0;
    end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL full_busy_done got=%b exp=1", busy); end
    tick();
    n_cmp++; if (weight_wr_en !== 1'b0) begin n_err++; $display("FAIL full_post_en got=%b exp=0", weight_wr_en); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL full_post_done got=%b exp=0", done); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL full_post_busy got=%b exp=0", busy); end
    n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL full_post_ready got=%b exp=0", s_ready); end
    n_cmp++; if (q.size() != 0) begin n_err++; $display("FAIL full_left got=%0d exp=0", q.size()); end
    q.delete();
  endtask

  task automatic test_coeff_mask();
    logic [31:0] d;
    logic [31:0] x;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 40; n++) begin
      d = $urandom();
      x = d;
      if (n == 38) begin d = 32'hDEAD_8000; x = 32'h0000_8000; end
      if (n == 39) begin d = 32'h1234_0800; x = 32'h0000_0800; end
      s_valid = 1'b1;
      s_data = d;
      q.push_back('{addr: 32'(n), data: x});
      tick();
      if (weight_wr_en !== 1'b1 || q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL mask_en n=%0d got=%b exp=1", n, weight_wr_en);
      end else begin
        e = q.pop_front();
        n_cmp++;
        if (weight_wr_addr !== e.addr || weight_wr_data !== e.data) begin
          n_err++;
          $display("FAIL mask_wr n=%0d got=%h/%h exp=%h/%h", n, weight_wr_addr, weight_wr_data, e.addr, e.data);
        end
      end
    end
    s_valid = 1'b0;
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL mask_done got=%b exp=1", done); end
    tick();
    q.delete();
  endtask

  task automatic test_valid_toggle();
    int n;
    int c;
    logic v;
    n = 0;
    c = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (n < 40 && c < 200) begin
      v = (c % 2 == 0);
      s_valid = v;
      s_data = 32'(n + 100);
      if (v) q.push_back('{addr: 32'(n), data: 32'(n + 100)});
      tick();
      if (v) n++;
      n_cmp++; if (weight_wr_en !== v) begin n_err++; $display("FAIL tog_en c=%0d got=%b exp=%b", c, weight_wr_en, v); end
      if (weight_wr_en === 1'b1 && q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (weight_wr_addr !== e.addr || weight_wr_data !== e.data) begin
          n_err++;
          $display("FAIL tog_wr c=%0d got=%h/%h exp=%h/%h", c, weight_wr_addr, weight_wr_data, e.addr, e.data);
        end
      end
      n_cmp++; if (done !== (v && n == 40)) begin n_err++; $display("FAIL tog_done c=%0d got=%b exp=%b", c, done, v && n == 40); end
      c++;
    end
    s_valid = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL tog_busy got=%b exp=0", busy); end
    n_cmp++; if (q.size() != 0) begin n_err++; $display("FAIL tog_left got=%0d exp=0", q.size()); end
    q.delete();
  endtask

  task automatic test_abort();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 20; n++) begin
      s_valid = 1'b1;
      s_data = 32'(n + 500);
      q.push_back('{addr: 32'(n), data: 32'(n + 500)});
      tick();
      if (weight_wr_en === 1'b1 && q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (weight_wr_addr !== e.addr || weight_wr_data !== e.data) begin
          n_err++;
          $display("FAIL abt_wr n=%0d got=%h/%h exp=%h/%h", n, weight_wr_addr, weight_wr_data, e.addr, e.data);
        end
      end else begin
        n_cmp++; n_err++;
        $display("FAIL abt_en n=%0d got=%b exp=1", n, weight_wr_en);
      end
    end
    abort = 1'b1;
    s_valid = 1'b1;
    s_data = 32'hAAAA_5555;
    tick();
    abort = 1'b0;
    n_cmp++; if (weight_wr_en !== 1'b0) begin n_err++; $display("FAIL abt_edge_en got=%b exp=0", weight_wr_en); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abt_busy got=%b exp=0", busy); end
    n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL abt_ready got=%b exp=0", s_ready); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL abt_done got=%b exp=0", done); end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++;
      if (weight_wr_en !== 1'b0 || done !== 1'b0) begin
        n_err++;
        $display("FAIL abt_idle k=%0d got=%b/%b exp=0/0", k, weight_wr_en, done);
      end
    end
    s_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 5; n++) begin
      s_valid = 1'b1;
      s_data = 32'(n + 900);
      q.push_back('{addr: 32'(n), data: 32'(n + 900)});
      tick();
      if (weight_wr_en === 1'b1 && q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (weight_wr_addr !== e.addr || weight_wr_data !== e.data) begin
          n_err++;
          $display("FAIL reload_wr n=%0d got=%h/%h exp=%h/%h", n, weight_wr_addr, weight_wr_data, e.addr, e.data);
        end
      end else begin
        n_cmp++; n_err++;
        $display("FAIL reload_en n=%0d got=%b exp=1", n, weight_wr_en);
      end
    end
    s_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reload_abt_busy got=%b exp=0", busy); end
    q.delete();
  endtask

  task automatic test_start_busy_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 40; n++) begin
      start = (n == 10);
      s_valid = 1'b1;
      s_data = 32'(n + 7000);
      q.push_back('{addr: 32'(n), data: 32'(n + 7000)});
      tick();
      if (weight_wr_en === 1'b1 && q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (weight_wr_addr !== e.addr || weight_wr_data !== e.data) begin
          n_err++;
          $display("FAIL sb_wr n=%0d got=%h/%h exp=%h/%h", n, weight_wr_addr, weight_wr_data, e.addr, e.data);
        end
      end else begin
        n_cmp++; n_err++;
        $display("FAIL sb_en n=%0d got=%b exp=1", n, weight_wr_en);
      end
    end
    start = 1'b0;
    s_valid = 1'b0;
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL sb_done got=%b exp=1", done); end
    tick();
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL sb_idle got=%b exp=0", busy); end
    q.delete();

    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 5; n++) begin
      s_valid = 1'b1;
      s_data = 32'(n + 300);
      tick();
    end
    n_cmp++; if (weight_wr_addr !== 32'd4) begin n_err++; $display("FAIL rmid_addr got=%h exp=4", weight_wr_addr); end
    rst_n = 1'b0;
    s_data = 32'h5A5A_5A5A;
    tick();
    n_cmp++; if (weight_wr_en !== 1'b0) begin n_err++; $display("FAIL rmid_en got=%b exp=0", weight_wr_en); end
    n_cmp++; if (weight_wr_addr !== 32'd0) begin n_err++; $display("FAIL rmid_addr0 got=%h exp=0", weight_wr_addr); end
    n_cmp++; if (weight_wr_data !== 32'd0) begin n_err++; $display("FAIL rmid_data got=%h exp=0", weight_wr_data); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL rmid_ready got=%b exp=0", s_ready); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rmid_done got=%b exp=0", done); end
    rst_n = 1'b1;
    s_valid = 1'b0;
    tick();
  endtask

  task automatic test_small_params();
    logic [31:0] d;
    logic [31:0] x;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int n = 0; n < 42; n++) begin
      d = $urandom();
      x = (n >= 40) ? (d & 32'h0000_FFFF) : d;
      s_valid_b = 1'b1;
      s_data_b = d;
      q.push_back('{addr: 32'(n), data: x});
      tick();
      if (wr_en_b === 1'b1 && q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (wr_addr_b !== e.addr || wr_data_b !== e.data) begin
          n_err++;
          $display("FAIL small_wr n=%0d got=%h/%h exp=%h/%h", n, wr_addr_b, wr_data_b, e.addr, e.data);
        end
      end else begin
        n_cmp++; n_err++;
        $display("FAIL small_en n=%0d got=%b exp=1", n, wr_en_b);
      end
      n_cmp++; if (done_b !== (n == 41)) begin n_err++; $display("FAIL small_done n=%0d got=%b exp=%b", n, done_b, n == 41); end
    end
    s_valid_b = 1'b0;
    tick();
    n_cmp++; if (busy_b !== 1'b0) begin n_err++; $display("FAIL small_busy got=%b exp=0", busy_b); end
    q.delete();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    s_data = '0;
    s_valid = 1'b0;
    start_b = 1'b0;
    abort_b = 1'b0;
    s_data_b = '0;
    s_valid_b = 1'b0;
    test_reset();
    test_full_load();
    test_coeff_mask();
    test_valid_toggle();
    test_abort();
    test_start_busy_reset();
    test_small_params();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
